// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding fetch to a variable-latency
// instruction memory, one-entry skid buffer and the IF/ID pipeline register.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc_i,
  input  logic        redirect_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rdy_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_inst_o,
  output logic        ifid_valid_o
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] drain_addr, drain_addr_nxt;
  logic [31:0] ifid_pc, ifid_pc_nxt;
  logic [31:0] ifid_inst, ifid_inst_nxt;
  logic        ifid_valid, ifid_valid_nxt;
  logic [31:0] skid_pc, skid_pc_nxt;
  logic [31:0] skid_inst, skid_inst_nxt;
  logic        accept;

  assign accept = !ifid_valid || !stall_i;

  // A request is outstanding in FETCH and DRAIN; DRAIN keeps presenting the
  // abandoned address so the memory sees a stable request until it answers.
  assign imem_req_o   = !rst && (state != HOLD);
  assign imem_addr_o  = (state == DRAIN) ? drain_addr : pc;
  assign pc_o         = pc;
  assign ifid_pc_o    = ifid_pc;
  assign ifid_inst_o  = ifid_inst;
  assign ifid_valid_o = ifid_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      drain_addr <= RESET_PC;
      ifid_pc    <= 32'h0;
      ifid_inst  <= NOP_INST;
      ifid_valid <= 1'b0;
      skid_pc    <= 32'h0;
      skid_inst  <= 32'h0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      drain_addr <= drain_addr_nxt;
      ifid_pc    <= ifid_pc_nxt;
      ifid_inst  <= ifid_inst_nxt;
      ifid_valid <= ifid_valid_nxt;
      skid_pc    <= skid_pc_nxt;
      skid_inst  <= skid_inst_nxt;
    end
  end

  // Redirect overrides everything: any word arriving this cycle is stale.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    drain_addr_nxt = drain_addr;
    ifid_pc_nxt    = ifid_pc;
    ifid_inst_nxt  = ifid_inst;
    ifid_valid_nxt = ifid_valid;
    skid_pc_nxt    = skid_pc;
    skid_inst_nxt  = skid_inst;

    if (redirect_i) begin
      pc_nxt         = npc_i;
      ifid_valid_nxt = 1'b0;
      ifid_inst_nxt  = NOP_INST;
      skid_pc_nxt    = 32'h0;
      skid_inst_nxt  = 32'h0;
      if (state != HOLD && !imem_rdy_i) begin
        state_nxt = DRAIN;
        if (state == FETCH) drain_addr_nxt = pc;
      end else begin
        state_nxt = FETCH;
      end
    end else begin
      case (state)
        FETCH: begin
          if (imem_rdy_i) begin
            if (accept) begin
              ifid_pc_nxt    = pc;
              ifid_inst_nxt  = imem_rdata_i;
              ifid_valid_nxt = 1'b1;
              pc_nxt         = npc_i;
            end else begin
              skid_pc_nxt   = pc;
              skid_inst_nxt = imem_rdata_i;
              state_nxt     = HOLD;
            end
          end else if (accept) begin
            ifid_valid_nxt = 1'b0;
            ifid_inst_nxt  = NOP_INST;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            ifid_pc_nxt    = skid_pc;
            ifid_inst_nxt  = skid_inst;
            ifid_valid_nxt = 1'b1;
            pc_nxt         = npc_i;
            state_nxt      = FETCH;
          end
        end
        DRAIN: begin
          if (imem_rdy_i) state_nxt = FETCH;
        end
        default: state_nxt = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios with literal checks,
// then randomized traffic compared every cycle against a queue-based reference model.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] npc_i;
  logic        redirect_i;
  logic        stall_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rdy_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_inst_o;
  logic        ifid_valid_o;

  int tests = 0;
  int fails = 0;

  // Reference model: fetch pc, IF/ID contents, parked words and a discard flag.
  logic [31:0] mPc;
  logic        mValid;
  logic [31:0] mIfPc;
  logic [31:0] mInst;
  logic        mDiscard;
  logic [31:0] mAbandon;
  logic [63:0] skidQ[$];

  if_fetch_stage dut (
    .clk(clk), .rst(rst), .npc_i(npc_i), .redirect_i(redirect_i), .stall_i(stall_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_rdy_i(imem_rdy_i),
    .imem_rdata_i(imem_rdata_i), .pc_o(pc_o), .ifid_pc_o(ifid_pc_o),
    .ifid_inst_o(ifid_inst_o), .ifid_valid_o(ifid_valid_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mPc = 32'h0; mValid = 1'b0; mIfPc = 32'h0; mInst = NOP;
    mDiscard = 1'b0; mAbandon = 32'h0; skidQ.delete();
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelUpdate();
    logic acc;
    logic inflight;
    acc = !mValid || !stall_i;
    inflight = (skidQ.size() == 0);
    if (rst) begin
      modelReset();
    end else if (redirect_i) begin
      if (inflight && !imem_rdy_i) begin
        if (!mDiscard) mAbandon = mPc;
        mDiscard = 1'b1;
      end else begin
        mDiscard = 1'b0;
      end
      skidQ.delete();
      mPc = npc_i; mValid = 1'b0; mInst = NOP;
    end else if (skidQ.size() != 0) begin
      if (!stall_i) begin
        {mIfPc, mInst} = skidQ.pop_front();
        mValid = 1'b1;
        mPc = npc_i;
      end
    end else if (mDiscard) begin
      if (imem_rdy_i) mDiscard = 1'b0;
    end else if (imem_rdy_i) begin
      if (acc) begin
        mIfPc = mPc; mInst = imem_rdata_i; mValid = 1'b1; mPc = npc_i;
      end else begin
        skidQ.push_back({mPc, imem_rdata_i});
      end
    end else if (acc) begin
      mValid = 1'b0; mInst = NOP;
    end
  endtask

  task automatic checkOutput(input logic expReq);
    check32("imem_req", {31'h0, imem_req_o}, {31'h0, expReq});
    if (expReq) check32("imem_addr", imem_addr_o, mDiscard ? mAbandon : mPc);
    check32("pc", pc_o, mPc);
    check32("ifid_valid", {31'h0, ifid_valid_o}, {31'h0, mValid});
    check32("ifid_inst", ifid_inst_o, mInst);
    if (mValid) check32("ifid_pc", ifid_pc_o, mIfPc);
  endtask

  // One clock: drive inputs at negedge, compare, then step the model at posedge.
  task automatic applyStimulus(input logic rstV, input logic stallV, input logic redirV,
                               input logic [31:0] tgt, input logic rdyV);
    logic expReq;
    @(negedge clk);
    expReq       = !rstV && (skidQ.size() == 0);
    rst          = rstV;
    stall_i      = stallV;
    redirect_i   = redirV;
    npc_i        = redirV ? tgt : mPc + 32'd4;
    imem_rdy_i   = rdyV && expReq;
    imem_rdata_i = mDiscard ? 32'hDEAD_BEEF : memWord(mPc);
    #1 checkOutput(expReq);
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  initial begin
    rst = 1'b1; npc_i = 32'h0; redirect_i = 1'b0; stall_i = 1'b0;
    imem_rdy_i = 1'b0; imem_rdata_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    applyStimulus(1, 0, 0, 32'h0, 0);
    check32("reset ifid_pc", ifid_pc_o, 32'h0);
    check32("reset inst", ifid_inst_o, NOP);
    check32("reset valid", {31'h0, ifid_valid_o}, 32'h0);
    check32("reset req", {31'h0, imem_req_o}, 32'h0);

    // Back-to-back single-cycle memory: one instruction per cycle.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 32'h0, 1);
      check32("stream ifid_pc", ifid_pc_o, 32'(i * 4));
      check32("stream valid", {31'h0, ifid_valid_o}, 32'h1);
    end

    // Memory answers every third cycle: two bubbles between instructions.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 0, 0, 32'h0, (k % 3) == 2);
      if ((k % 3) != 2) check32("bubble inst", ifid_inst_o, NOP);
    end
    check32("slow ifid_pc", ifid_pc_o, 32'h14);
    check32("slow pc", pc_o, 32'h18);

    // Stall while a word arrives: it parks, req drops, released next edge.
    for (int k = 0; k < 4; k++) applyStimulus(0, 1, 0, 32'h0, 1);
    check32("stall ifid_pc", ifid_pc_o, 32'h14);
    check32("hold req", {31'h0, imem_req_o}, 32'h0);
    applyStimulus(0, 0, 0, 32'h0, 0);
    check32("release ifid_pc", ifid_pc_o, 32'h18);
    check32("release pc", pc_o, 32'h1C);

    // Redirect with a request in flight: drain, drop the late word.
    applyStimulus(0, 0, 0, 32'h0, 1);
    applyStimulus(0, 0, 1, 32'h100, 0);
    check32("drain addr", imem_addr_o, 32'h20);
    check32("flush valid", {31'h0, ifid_valid_o}, 32'h0);
    check32("redirect pc", pc_o, 32'h100);
    applyStimulus(0, 0, 0, 32'h0, 1);
    check32("dropped valid", {31'h0, ifid_valid_o}, 32'h0);
    applyStimulus(0, 0, 0, 32'h0, 1);
    check32("target ifid_pc", ifid_pc_o, 32'h100);
    check32("target inst", ifid_inst_o, memWord(32'h100));

    // Redirect together with stall while holding a parked word.
    applyStimulus(0, 1, 0, 32'h0, 1);
    applyStimulus(0, 1, 1, 32'h200, 0);
    check32("hold flush valid", {31'h0, ifid_valid_o}, 32'h0);
    check32("hold flush addr", imem_addr_o, 32'h200);
    applyStimulus(0, 0, 0, 32'h0, 1);
    check32("hold flush ifid_pc", ifid_pc_o, 32'h200);

    // Reset in the middle of a drain.
    applyStimulus(0, 0, 1, 32'h300, 0);
    applyStimulus(1, 0, 0, 32'h0, 0);
    check32("rst drain req", {31'h0, imem_req_o}, 32'h0);
    check32("rst drain pc", pc_o, 32'h0);
    applyStimulus(0, 0, 0, 32'h0, 1);
    check32("post rst ifid_pc", ifid_pc_o, 32'h0);

    // Randomized traffic, including redirects near the top of the address space.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : {$urandom(), 2'b00} >> 0;
      tgt[1:0] = 2'b00;
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 11) == 0, tgt, $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
